beta_stim_sequencer: RTL and testbench

BETA_STIM_SEQUENCER -- requirements
Module: beta_stim_sequencer

---
 rtl/beta_stim_pkg.sv | 29 ++
 rtl/stim_lfsr.sv | 23 ++
 rtl/beta_stim_sequencer.sv | 151 +++++++++++++++
 tb/tb_beta_stim_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_stim_pkg.sv
// Shared types and constants for the Beta stimulus sequencer: modes, FSM states, opcode legality, LFSR taps.
package beta_stim_pkg;

    typedef enum logic [1:0] {
        MODE_RANDOM   = 2'd0,
        MODE_DIRECTED = 2'd1,
        MODE_REPLAY   = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [5:0] OP_ADDC = 6'h30;

    // Bit n set means opcode n is a defined Beta instruction (memory/branch 0x18-0x1F, ALU and ALU-constant groups).
    localparam logic [63:0] LEGAL_OP_MASK = 64'h7F7F_7F7F_BB00_0000;

    // Galois right-shift taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [5:0] legal_opcode(input logic [5:0] op);
        return LEGAL_OP_MASK[op] ? op : OP_ADDC;
    endfunction

endpackage

// File: rtl/stim_lfsr.sv
// Galois LFSR holding the current pseudo-random word.
// Latency: new state visible the cycle after advance.
// Backpressure: state holds whenever advance is low.
module stim_lfsr #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = 'h1,
    parameter logic [WIDTH-1:0] POLY  = 'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (advance) begin
            state <= state[0] ? ((state >> 1) ^ POLY) : (state >> 1);
        end
    end

endmodule

// File: rtl/beta_stim_sequencer.sv
// Instruction stimulus sequencer: RANDOM (LFSR), DIRECTED and REPLAY streams; BETA_STIM_OPCODE_FILTER_EN legalises random opcodes.
// Latency: first out_valid the cycle after start, then one instruction per cycle.
// Backpressure: out_inst held while out_valid && !out_ready; loads accepted only in IDLE with space.
module beta_stim_sequencer
    import beta_stim_pkg::*;
#(
    parameter int                INST_W = 32,
    parameter int                DEPTH  = 16,
    parameter int                CNT_W  = 16,
    parameter logic [INST_W-1:0] SEED   = 32'h1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             cfg_mode,
    input  logic [CNT_W-1:0]       num_inst,
    input  logic                   start,
    input  logic                   load_valid,
    input  logic [INST_W-1:0]      load_inst,
    output logic                   load_ready,
    output logic                   out_valid,
    output logic [INST_W-1:0]      out_inst,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       emitted,
    output logic [$clog2(DEPTH):0] buf_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int BW = PW + 1;

    state_e            state;
    logic              rand_sel;
    logic [CNT_W-1:0]  left;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     last_idx;
    logic [INST_W-1:0] dir_q;
    logic [INST_W-1:0] mem [DEPTH];
    logic [INST_W-1:0] lfsr_state;
    logic [INST_W-1:0] rand_inst;
    logic [CNT_W-1:0]  start_len;
    mode_e             start_mode;
    logic              start_rand;
    logic              xfer;
    logic              load_fire;

    assign xfer       = out_valid && out_ready;
    assign load_ready = (state == ST_IDLE) && (buf_count < BW'(DEPTH));
    assign load_fire  = load_valid && load_ready;
    assign start_mode = mode_e'(cfg_mode);
    assign start_rand = (start_mode == MODE_RANDOM) || (start_mode == MODE_RSVD);

    // Run length is fixed at start; DIRECTED uses the occupancy seen before any same-cycle load.
    always_comb begin
        start_len = num_inst;
        case (start_mode)
            MODE_DIRECTED: start_len = CNT_W'(buf_count);
            MODE_REPLAY:   if (buf_count == '0) start_len = '0;
            default:       ;
        endcase
    end

    stim_lfsr #(
        .WIDTH (INST_W),
        .SEED  (SEED),
        .POLY  (LFSR_POLY[INST_W-1:0])
    ) u_lfsr (
        .clk     (CLK),
        .rst     (RST),
        .advance (xfer && rand_sel),
        .state   (lfsr_state)
    );

`ifdef BETA_STIM_OPCODE_FILTER_EN
    always_comb begin
        rand_inst                   = lfsr_state;
        rand_inst[INST_W-1 -: 6]    = legal_opcode(lfsr_state[INST_W-1 -: 6]);
    end
`else
    assign rand_inst = lfsr_state;
`endif

    assign out_inst = rand_sel ? rand_inst : dir_q;

    always_ff @(posedge CLK) begin
        if (load_fire) begin
            mem[buf_count[PW-1:0]] <= load_inst;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            emitted   <= '0;
            buf_count <= '0;
            left      <= '0;
            rd_ptr    <= '0;
            last_idx  <= '0;
            dir_q     <= '0;
            rand_sel  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_fire) begin
                buf_count <= buf_count + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        emitted  <= '0;
                        rand_sel <= start_rand;
                        left     <= start_len;
                        if (start_len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_RUN;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                            // rd_ptr always names the entry to present after the next transfer.
                            dir_q     <= mem[0];
                            last_idx  <= PW'(buf_count - 1'b1);
                            rd_ptr    <= (buf_count == BW'(1)) ? '0 : PW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (emitted != '1) begin
                            emitted <= emitted + 1'b1;
                        end
                        left   <= left - 1'b1;
                        dir_q  <= mem[rd_ptr];
                        rd_ptr <= (rd_ptr == last_idx) ? '0 : rd_ptr + 1'b1;
                        if (left == CNT_W'(1)) begin
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beta_stim_sequencer.sv
// Bench for beta_stim_sequencer: queue-based stream model checked every cycle plus directed literal checks.
module tb_beta_stim_sequencer;

    localparam int          DEPTH = 16;
    localparam int          CNT_W = 16;
    localparam logic [31:0] SEED  = 32'h1;

    logic        CLK;
    logic        RST;
    logic [1:0]  cfg_mode;
    logic [15:0] num_inst;
    logic        start;
    logic        load_valid;
    logic [31:0] load_inst;
    logic        load_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] emitted;
    logic [4:0]  buf_count;

    int checks = 0;
    int errors = 0;

    beta_stim_sequencer #(
        .INST_W (32),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .SEED   (SEED)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cfg_mode   (cfg_mode),
        .num_inst   (num_inst),
        .start      (start),
        .load_valid (load_valid),
        .load_inst  (load_inst),
        .load_ready (load_ready),
        .out_valid  (out_valid),
        .out_inst   (out_inst),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .emitted    (emitted),
        .buf_count  (buf_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef BETA_STIM_OPCODE_FILTER_EN
    logic [63:0] legal_mask = 64'h7F7F_7F7F_BB00_0000;
`endif

    function automatic logic [31:0] filt(input logic [31:0] v);
        logic [31:0] r;
        r = v;
`ifdef BETA_STIM_OPCODE_FILTER_EN
        if (!legal_mask[v[31:26]]) r[31:26] = 6'h30;
`endif
        return r;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Reference model: phase 0 idle, 1 running, 2 done; the whole run is precomputed as a queue at start.
    int          m_phase   = 0;
    int          m_emitted = 0;
    logic [31:0] m_lfsr    = SEED;
    logic [31:0] m_buf[$];
    logic [31:0] m_stream[$];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_phase   = 0;
            m_emitted = 0;
            m_lfsr    = SEED;
            m_buf.delete();
            m_stream.delete();
        end else if (m_phase == 0) begin
            if (start) begin
                m_stream.delete();
                m_emitted = 0;
                case (cfg_mode)
                    2'd1: foreach (m_buf[i]) m_stream.push_back(m_buf[i]);
                    2'd2: if (m_buf.size() > 0)
                        for (int i = 0; i < int'(num_inst); i++) m_stream.push_back(m_buf[i % m_buf.size()]);
                    default:
                        for (int i = 0; i < int'(num_inst); i++) begin
                            m_stream.push_back(filt(m_lfsr));
                            m_lfsr = lfsr_step(m_lfsr);
                        end
                endcase
                m_phase = (m_stream.size() == 0) ? 2 : 1;
            end
            if (load_valid && m_buf.size() < DEPTH) m_buf.push_back(load_inst);
        end else if (m_phase == 1) begin
            if (out_ready) begin
                void'(m_stream.pop_front());
                if (m_emitted != 65535) m_emitted++;
                if (m_stream.size() == 0) m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge CLK) begin
        chk("m_out_valid",  out_valid,  m_phase == 1);
        chk("m_busy",       busy,       m_phase == 1);
        chk("m_done",       done,       m_phase == 2);
        chk("m_emitted",    emitted,    m_emitted);
        chk("m_buf_count",  buf_count,  m_buf.size());
        chk("m_load_ready", load_ready, (m_phase == 0) && (m_buf.size() < DEPTH));
        if (m_phase == 1 && m_stream.size() > 0) chk("m_out_inst", out_inst, m_stream[0]);
    end

    logic [31:0] got[$];
    int          done_cyc;

    task automatic run(input logic [1:0] mode, input int n, input bit toggle, input int budget);
        got.delete();
        done_cyc  = -1;
        cfg_mode  = mode;
        num_inst  = n[15:0];
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge CLK); #1;
        start      = 1'b0;
        load_valid = 1'b0;
        for (int c = 0; c < budget && done_cyc < 0; c++) begin
            @(negedge CLK);
            if (done) done_cyc = c;
            else if (out_valid && out_ready) got.push_back(out_inst);
            @(posedge CLK); #1;
            if (toggle) out_ready = ~out_ready;
        end
        chk("run_done_seen", done_cyc >= 0, 1'b1);
    endtask

    task automatic load_word(input logic [31:0] w);
        load_valid = 1'b1;
        load_inst  = w;
        @(posedge CLK); #1;
        load_valid = 1'b0;
    endtask

    logic [31:0] abc [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
`ifndef BETA_STIM_OPCODE_FILTER_EN
    logic [31:0] rand_exp [4] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
`endif

    initial begin
        RST = 1'b1; start = 1'b0; cfg_mode = 2'd0; num_inst = '0;
        load_valid = 1'b0; load_inst = '0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid",  out_valid,  1'b0);
        chk("rst_out_inst",   out_inst,   32'h0);
        chk("rst_busy",       busy,       1'b0);
        chk("rst_done",       done,       1'b0);
        chk("rst_emitted",    emitted,    16'h0);
        chk("rst_buf_count",  buf_count,  5'd0);
        chk("rst_load_ready", load_ready, 1'b1);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // RANDOM, four back-to-back transfers from SEED
        run(2'd0, 4, 1'b0, 40);
        chk("rand_count",    got.size(), 4);
        chk("rand_done_cyc", done_cyc,   4);
        chk("rand_emitted",  emitted,    16'd4);
`ifndef BETA_STIM_OPCODE_FILTER_EN
        for (int i = 0; i < got.size() && i < 4; i++) chk("rand_word", got[i], rand_exp[i]);
`endif

        // DIRECTED with out_ready toggling
        for (int i = 0; i < 3; i++) load_word(abc[i]);
        chk("dir_buf_count", buf_count, 5'd3);
        run(2'd1, 9, 1'b1, 40);
        chk("dir_count",    got.size(), 3);
        chk("dir_done_cyc", done_cyc,   5);
        for (int i = 0; i < got.size() && i < 3; i++) chk("dir_word", got[i], abc[i]);

        // REPLAY wraps through the three entries
        run(2'd2, 7, 1'b0, 40);
        chk("rep_count",    got.size(), 7);
        chk("rep_done_cyc", done_cyc,   7);
        for (int i = 0; i < got.size() && i < 7; i++) chk("rep_word", got[i], abc[i % 3]);

        // Reset mid-run after two of five transfers
        cfg_mode = 2'd0; num_inst = 16'd5; out_ready = 1'b1; start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        chk("pre_rst_emitted", emitted, 16'd2);
        chk("pre_rst_busy",    busy,    1'b1);
        RST = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_busy",      busy,      1'b0);
        chk("mid_rst_emitted",   emitted,   16'h0);
        chk("mid_rst_buf_count", buf_count, 5'd0);
        @(negedge CLK);
        chk("mid_rst_no_done", done, 1'b0);
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_no_done", done, 1'b0);
        @(posedge CLK); #1;

        // Empty DIRECTED start with a same-cycle load: zero-length run, load still taken
        load_valid = 1'b1; load_inst = 32'd100;
        run(2'd1, 0, 1'b0, 20);
        chk("zero_dir_done_cyc", done_cyc,   0);
        chk("zero_dir_count",    got.size(), 0);
        chk("zero_dir_buf",      buf_count,  5'd1);
        run(2'd2, 0, 1'b0, 20);
        chk("zero_rep_done_cyc", done_cyc,   0);
        chk("zero_rep_count",    got.size(), 0);

        // Fill past DEPTH: the extra word must be refused
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1'b1;
            load_inst  = 32'(101 + i);
            @(negedge CLK);
            if (i == DEPTH - 2) chk("load_ready_last_slot", load_ready, 1'b1);
            if (i == DEPTH - 1) chk("load_ready_full",      load_ready, 1'b0);
            @(posedge CLK); #1;
        end
        load_valid = 1'b0;
        chk("full_buf_count", buf_count, 5'd16);
        run(2'd1, 0, 1'b0, 64);
        chk("full_dir_count",    got.size(), DEPTH);
        chk("full_dir_done_cyc", done_cyc,   DEPTH);
        for (int i = 0; i < got.size() && i < DEPTH; i++) chk("full_dir_word", got[i], 32'(100 + i));

        // Long run in the reserved mode, which behaves as RANDOM
        run(2'd3, 1000, 1'b0, 1100);
        chk("long_count",   got.size(), 1000);
        chk("long_emitted", emitted,    16'd1000);
`ifdef BETA_STIM_OPCODE_FILTER_EN
        begin
            int bad;
            bad = 0;
            foreach (got[i]) if (!legal_mask[got[i][31:26]]) bad++;
            chk("long_illegal_opcodes", bad, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
